// File: rtl/riscv_boot_pkg.sv
// rtl/riscv_boot_pkg.sv - boot loader state encoding and SRAM control constants
package riscv_boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    VERIFY = 3'd2,
    RUN    = 3'd3,
    ERROR  = 3'd4
  } boot_state_t;

  localparam logic       CSN_ON  = 1'b0;
  localparam logic       CSN_OFF = 1'b1;
  localparam logic       WEN_WR  = 1'b0;
  localparam logic       WEN_RD  = 1'b1;
  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - image stream, core fetch port and I-memory SRAM port bundle
interface imem_boot_loader_if #(
  parameter int AWIDTH = 10
);
  logic              S_VALID;
  logic              S_READY;
  logic [31:0]       S_DATA;
  logic              S_LAST;
  logic              CPU_I_MEM_CSN;
  logic [AWIDTH+1:0] CPU_I_MEM_ADDR;
  logic              MEM_CSN;
  logic              MEM_WEN;
  logic [3:0]        MEM_BE;
  logic [AWIDTH-1:0] MEM_ADDR;
  logic [31:0]       MEM_DI;
  logic [31:0]       MEM_DOUT;

  // master: the environment around the loader (stream source, core, SRAM)
  modport master (
    output S_VALID, S_DATA, S_LAST, CPU_I_MEM_CSN, CPU_I_MEM_ADDR, MEM_DOUT,
    input  S_READY, MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI
  );

  modport slave (
    input  S_VALID, S_DATA, S_LAST, CPU_I_MEM_CSN, CPU_I_MEM_ADDR, MEM_DOUT,
    output S_READY, MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI
  );
endinterface

// File: rtl/imem_port_mux.sv
// rtl/imem_port_mux.sv - selects loader or core as owner of the I-memory SRAM port
module imem_port_mux
  import riscv_boot_pkg::*;
#(
  parameter int AWIDTH = 10
) (
  input  logic              core_sel,
  input  logic              ld_csn,
  input  logic              ld_wen,
  input  logic [3:0]        ld_be,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [31:0]       ld_di,
  input  logic              cpu_csn,
  input  logic [AWIDTH-1:0] cpu_word_addr,
  output logic              mem_csn,
  output logic              mem_wen,
  output logic [3:0]        mem_be,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_di
);

  // The core port is read-only: instruction fetch never writes I-memory.
  always_comb begin
    if (core_sel) begin
      mem_csn  = cpu_csn;
      mem_wen  = WEN_RD;
      mem_be   = BE_NONE;
      mem_addr = cpu_word_addr;
      mem_di   = '0;
    end else begin
      mem_csn  = ld_csn;
      mem_wen  = ld_wen;
      mem_be   = ld_be;
      mem_addr = ld_addr;
      mem_di   = ld_di;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads an image into I-memory, verifies its XOR checksum, releases the core
module imem_boot_loader
  import riscv_boot_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int SIZE   = 1024,
  parameter int DWIDTH = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              START,
  input  logic [DWIDTH-1:0] EXP_SUM,
  imem_boot_loader_if.slave bif,
  output logic              CORE_RSTn,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [AWIDTH:0]   WORD_CNT
);

  localparam logic [AWIDTH:0] SIZE_W = SIZE[AWIDTH:0];

  boot_state_t       state;
  logic [AWIDTH:0]   rd_ptr;
  logic              rd_valid;
  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] exp_sum_q;

  logic              s_ready;
  logic              accept;
  logic              rd_issue;
  logic              verify_end;
  logic [DWIDTH-1:0] acc_next;

  logic              ld_csn;
  logic              ld_wen;
  logic [3:0]        ld_be;
  logic [AWIDTH-1:0] ld_addr;
  logic [31:0]       ld_di;
  logic              unused_addr_lsb;

  assign s_ready    = (state == LOAD) && (WORD_CNT < SIZE_W);
  assign accept     = bif.S_VALID && s_ready;
  assign rd_issue   = (state == VERIFY) && (rd_ptr < WORD_CNT);
  assign acc_next   = rd_valid ? (acc ^ bif.MEM_DOUT) : acc;
  // Once all reads are issued, this cycle carries the last read data, so the
  // decision uses the folded-in value and verify takes WORD_CNT+1 cycles.
  assign verify_end = (state == VERIFY) && !rd_issue;

  assign bif.S_READY     = s_ready;
  assign unused_addr_lsb = ^bif.CPU_I_MEM_ADDR[1:0];

  always_comb begin
    ld_csn  = CSN_OFF;
    ld_wen  = WEN_RD;
    ld_be   = BE_NONE;
    ld_addr = '0;
    ld_di   = '0;
    if (accept) begin
      ld_csn  = CSN_ON;
      ld_wen  = WEN_WR;
      ld_be   = BE_ALL;
      ld_addr = WORD_CNT[AWIDTH-1:0];
      ld_di   = bif.S_DATA;
    end else if (rd_issue) begin
      ld_csn  = CSN_ON;
      ld_addr = rd_ptr[AWIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      WORD_CNT  <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      acc       <= '0;
      exp_sum_q <= '0;
      CORE_RSTn <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      rd_valid  <= rd_issue;
      // Core leaves reset only from the second RUN cycle, after the port mux has switched.
      CORE_RSTn <= (state == RUN);
      case (state)
        IDLE, ERROR: begin
          if (START) begin
            state     <= LOAD;
            exp_sum_q <= EXP_SUM;
            WORD_CNT  <= '0;
            rd_ptr    <= '0;
            acc       <= '0;
            BUSY      <= 1'b1;
            ERR       <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            WORD_CNT <= WORD_CNT + 1'b1;
            if (bif.S_LAST || (WORD_CNT == SIZE_W - 1'b1)) begin
              state <= VERIFY;
            end
          end
        end
        VERIFY: begin
          acc <= acc_next;
          if (rd_issue) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (verify_end) begin
            BUSY <= 1'b0;
            if (acc_next == exp_sum_q) begin
              state <= RUN;
              DONE  <= 1'b1;
            end else begin
              state <= ERROR;
              ERR   <= 1'b1;
            end
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  imem_port_mux #(
    .AWIDTH (AWIDTH)
  ) u_port_mux (
    .core_sel      (CORE_RSTn),
    .ld_csn        (ld_csn),
    .ld_wen        (ld_wen),
    .ld_be         (ld_be),
    .ld_addr       (ld_addr),
    .ld_di         (ld_di),
    .cpu_csn       (bif.CPU_I_MEM_CSN),
    .cpu_word_addr (bif.CPU_I_MEM_ADDR[AWIDTH+1:2]),
    .mem_csn       (bif.MEM_CSN),
    .mem_wen       (bif.MEM_WEN),
    .mem_be        (bif.MEM_BE),
    .mem_addr      (bif.MEM_ADDR),
    .mem_di        (bif.MEM_DI)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed table and sequence bench for imem_boot_loader
module tb_imem_boot_loader;
  localparam int AW = 10;
  localparam int SZ = 4;

  typedef struct {
    bit              rst_first;
    logic [31:0]     exp_sum;
    int              n;
    int              last_at;
    bit              toggle;
    logic [5:0][31:0] w;
    int              exp_cnt;
    bit              exp_done;
    bit              exp_err;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          START = 1'b0;
  logic [31:0]   EXP_SUM = '0;
  logic          CORE_RSTn;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [AW:0]   WORD_CNT;

  int checks = 0;
  int errors = 0;
  int oob_writes = 0;
  int core_viol = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  imem_boot_loader_if #(.AWIDTH(AW)) bif();

  imem_boot_loader #(.AWIDTH(AW), .SIZE(SZ), .DWIDTH(32)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .START     (START),
    .EXP_SUM   (EXP_SUM),
    .bif       (bif),
    .CORE_RSTn (CORE_RSTn),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .WORD_CNT  (WORD_CNT)
  );

  always #5 CLK = ~CLK;

  // SRAM model with one cycle read latency plus port-ownership monitors
  always @(posedge CLK) begin
    if (!bif.MEM_CSN) begin
      if (!bif.MEM_WEN) begin
        for (int b = 0; b < 4; b++)
          if (bif.MEM_BE[b]) mem[bif.MEM_ADDR][8*b +: 8] <= bif.MEM_DI[8*b +: 8];
        if (bif.MEM_ADDR >= SZ) oob_writes = oob_writes + 1;
      end else begin
        bif.MEM_DOUT <= mem[bif.MEM_ADDR];
      end
      if (CORE_RSTn && bif.CPU_I_MEM_CSN) core_viol = core_viol + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic pulse_start(input logic [31:0] sum);
    START = 1'b1;
    EXP_SUM = sum;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after acceptance or after the timeout.
  task automatic push(input logic [31:0] d, input bit last, output bit ok);
    ok = 1'b0;
    bif.S_VALID = 1'b1;
    bif.S_DATA  = d;
    bif.S_LAST  = last;
    for (int t = 0; t < 8 && !ok; t++) begin
      if (bif.S_READY) ok = 1'b1;
      @(negedge CLK);
    end
    bif.S_VALID = 1'b0;
    bif.S_LAST  = 1'b0;
  endtask

  task automatic wait_outcome(output bit got);
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      if (DONE || ERR) got = 1'b1;
      else @(negedge CLK);
    end
  endtask

  function automatic vec_t mk(input bit rst, input logic [31:0] sum, input int n, input int last_at,
                              input bit tog, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4,
                              input logic [31:0] w5, input int cnt, input bit dn, input bit er);
    vec_t v;
    v.rst_first = rst; v.exp_sum = sum; v.n = n; v.last_at = last_at; v.toggle = tog;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
    v.exp_cnt = cnt; v.exp_done = dn; v.exp_err = er;
    return v;
  endfunction

  vec_t vecs [7];
  bit   ok;
  bit   got;
  int   acc_n;

  initial begin
    vecs[0] = mk(1, 32'h0000_0ABC, 2, 1, 0, 32'h13, 32'hAAF, 0, 0, 0, 0, 2, 1, 0);
    vecs[1] = mk(1, 32'h0000_0000, 2, 1, 0, 32'h13, 32'hAAF, 0, 0, 0, 0, 2, 0, 1);
    vecs[2] = mk(0, 32'h0000_0ABC, 2, 1, 0, 32'h13, 32'hAAF, 0, 0, 0, 0, 2, 1, 0);
    vecs[3] = mk(1, 32'h0000_000F, 6, -1, 1, 32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 4, 1, 0);
    vecs[4] = mk(1, 32'h1234_5678, 1, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[5] = mk(1, 32'hFFFF_FFFF, 4, 3, 0, 32'hA5, 32'h5A, 32'h3C, 32'hC3, 0, 0, 4, 0, 1);
    vecs[6] = mk(0, 32'h0000_000D, 3, 2, 1, 32'hA, 32'hB, 32'hC, 0, 0, 0, 3, 1, 0);

    bif.S_VALID = 1'b0;
    bif.S_DATA = '0;
    bif.S_LAST = 1'b0;
    bif.CPU_I_MEM_CSN = 1'b0;
    bif.CPU_I_MEM_ADDR = '0;

    // Reset state, with the core requesting the port throughout
    repeat (2) @(negedge CLK);
    chk("rst_core_rstn", CORE_RSTn, 0);
    chk("rst_mem_csn", bif.MEM_CSN, 1);
    chk("rst_mem_wen", bif.MEM_WEN, 1);
    chk("rst_mem_be", bif.MEM_BE, 0);
    chk("rst_mem_addr", bif.MEM_ADDR, 0);
    chk("rst_mem_di", bif.MEM_DI, 0);
    chk("rst_s_ready", bif.S_READY, 0);
    chk("rst_status", {BUSY, DONE, ERR}, 0);
    chk("rst_word_cnt", WORD_CNT, 0);

    // START with S_VALID in IDLE: the word is not taken
    RSTn = 1'b1;
    @(negedge CLK);
    START = 1'b1; EXP_SUM = 32'h0000_0ABC;
    bif.S_VALID = 1'b1; bif.S_DATA = 32'h55;
    chk("idle_start_ready", bif.S_READY, 0);
    @(negedge CLK);
    START = 1'b0; bif.S_VALID = 1'b0;
    chk("idle_start_cnt", WORD_CNT, 0);
    chk("load_busy", BUSY, 1);
    chk("load_ready", bif.S_READY, 1);

    // Good image with a START during LOAD that must not relatch EXP_SUM
    push(32'h13, 1'b0, ok);
    pulse_start(32'h0);
    chk("load_start_ignored_cnt", WORD_CNT, 1);
    push(32'hAAF, 1'b1, ok);
    chk("lat_v1_busy", {BUSY, DONE}, 2'b10);
    @(negedge CLK);
    chk("lat_v2_done", DONE, 0);
    @(negedge CLK);
    chk("lat_v3_done", {BUSY, DONE}, 2'b10);
    @(negedge CLK);
    chk("lat_run_done", {BUSY, DONE, ERR}, 3'b010);
    chk("lat_run_core_rstn", CORE_RSTn, 0);
    chk("lat_run_mem_csn", bif.MEM_CSN, 1);
    @(negedge CLK);
    chk("lat_core_rstn_up", CORE_RSTn, 1);
    chk("core_owns_csn", bif.MEM_CSN, 0);
    bif.CPU_I_MEM_ADDR = 12'h004;
    #1;
    chk("fetch_addr", bif.MEM_ADDR, 1);
    chk("fetch_ctl", {bif.MEM_WEN, bif.MEM_BE}, 5'b10000);
    @(negedge CLK);
    chk("fetch_data", bif.MEM_DOUT, 32'h0000_0AAF);
    pulse_start(32'h0);
    chk("run_start_ignored", {BUSY, DONE, CORE_RSTn}, 3'b011);
    bif.CPU_I_MEM_CSN = 1'b1;
    #1;
    chk("core_csn_follow", bif.MEM_CSN, 1);
    bif.CPU_I_MEM_CSN = 1'b0;

    // Table-driven images
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_first) do_reset();
      pulse_start(vecs[i].exp_sum);
      acc_n = 0;
      for (int j = 0; j < vecs[i].n; j++) begin
        if (vecs[i].toggle && (j % 2 == 1)) @(negedge CLK);
        push(vecs[i].w[j], j == vecs[i].last_at, ok);
        if (ok) acc_n++;
      end
      wait_outcome(got);
      chk($sformatf("v%0d_outcome", i), got, 1);
      chk($sformatf("v%0d_done", i), DONE, vecs[i].exp_done);
      chk($sformatf("v%0d_err", i), ERR, vecs[i].exp_err);
      chk($sformatf("v%0d_word_cnt", i), WORD_CNT, vecs[i].exp_cnt);
      chk($sformatf("v%0d_accepted", i), acc_n, vecs[i].exp_cnt);
      for (int j = 0; j < vecs[i].exp_cnt; j++)
        chk($sformatf("v%0d_mem%0d", i, j), mem[j], vecs[i].w[j]);
      @(negedge CLK);
      @(negedge CLK);
      chk($sformatf("v%0d_core_rstn", i), CORE_RSTn, vecs[i].exp_done);
      if (vecs[i].exp_err) chk($sformatf("v%0d_err_csn", i), bif.MEM_CSN, 1);
    end

    // Abort mid-load with an asynchronous reset, then reload a small loop image
    do_reset();
    pulse_start(32'h0010_806F);
    push(32'h0000_0093, 1'b0, ok);
    push(32'h0010_8093, 1'b0, ok);
    #2 RSTn = 1'b0;
    #1;
    chk("abort_status", {BUSY, DONE, ERR, CORE_RSTn}, 0);
    chk("abort_ready", bif.S_READY, 0);
    chk("abort_csn", bif.MEM_CSN, 1);
    chk("abort_cnt", WORD_CNT, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    pulse_start(32'h0010_806F);
    push(32'h0000_0093, 1'b0, ok);
    push(32'h0010_8093, 1'b0, ok);
    push(32'h0000_006F, 1'b1, ok);
    wait_outcome(got);
    chk("reload_done", {got, DONE, ERR}, 3'b110);
    repeat (2) @(negedge CLK);
    chk("reload_core_rstn", CORE_RSTn, 1);
    bif.CPU_I_MEM_ADDR = 12'h008;
    @(negedge CLK);
    chk("reload_fetch", bif.MEM_DOUT, 32'h0000_006F);

    chk("no_oob_writes", oob_writes, 0);
    chk("no_core_port_violation", core_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
